// File: rtl/mips_alu_pkg.sv
// Shared constants for the MIPS32 execute stage: ALU function codes,
// opcode/funct encodings and branch-type codes from the main decoder.
package mips_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_ADDU  = 4'h1,
    ALU_SUB   = 4'h2,
    ALU_SUBU  = 4'h3,
    ALU_AND   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_XOR   = 4'h6,
    ALU_SLT   = 4'h7,
    ALU_SLTU  = 4'h8,
    ALU_SLL   = 4'h9,
    ALU_SRL   = 4'hA,
    ALU_SRA   = 4'hB,
    ALU_MULT  = 4'hC,
    ALU_MULTU = 4'hD,
    ALU_DIV   = 4'hE,
    ALU_DIVU  = 4'hF
  } alu_fn_e;

  // Primary opcodes, inst[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;

  // R-type funct codes, inst[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Branch types supplied by the main decoder
  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_EQ     = 3'b001;
  localparam logic [2:0] BR_NE     = 3'b010;
  localparam logic [2:0] BR_LTZ    = 3'b011;
  localparam logic [2:0] BR_GEZ    = 3'b100;
  localparam logic [2:0] BR_LEZ    = 3'b101;
  localparam logic [2:0] BR_GTZ    = 3'b110;
  localparam logic [2:0] BR_ALWAYS = 3'b111;

endpackage

// File: rtl/mips_exec_unit_if.sv
// Execute-stage bus: decoder/operand inputs toward the unit (master drives),
// result, flags and branch decision back from it (slave drives).
interface mips_exec_unit_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  want;
  logic        flag_en;
  logic [3:0]  alu_f;
  logic [63:0] c;
  logic        ze;
  logic        si;
  logic        ov;
  logic        dz;
  logic        branch;
  logic [3:0]  flags_q;

  modport master (
    output op, func, a, b, want, flag_en,
    input  alu_f, c, ze, si, ov, dz, branch, flags_q
  );

  modport slave (
    input  op, func, a, b, want, flag_en,
    output alu_f, c, ze, si, ov, dz, branch, flags_q
  );
endinterface

// File: rtl/mips_exec_unit_alu_core.sv
// Combinational 64-bit-result ALU. Multiply/divide (codes C-F) exist only when
// ALU_MULDIV_EN is defined; otherwise those codes return zero with no flags.
module alu_core
  import mips_alu_pkg::*;
(
  input  alu_fn_e     i_f,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_c,
  output logic        o_ov,
  output logic        o_dz
);

  logic signed [31:0] w_as;
  logic signed [31:0] w_bs;
  logic [31:0]        w_sum;
  logic [31:0]        w_dif;
  logic               w_add_ov;
  logic               w_sub_ov;
  logic [4:0]         w_sh;

  assign w_as     = $signed(i_a);
  assign w_bs     = $signed(i_b);
  assign w_sum    = i_a + i_b;
  assign w_dif    = i_a - i_b;
  assign w_add_ov = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
  assign w_sub_ov = (i_a[31] != i_b[31]) && (w_dif[31] != i_a[31]);
  assign w_sh     = i_a[4:0];

`ifdef ALU_MULDIV_EN
  logic signed [63:0] w_as64;
  logic signed [63:0] w_bs64;
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_bzero;
  logic               w_div_edge;
  logic signed [31:0] w_bsafe;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic [31:0]        w_quo_u;
  logic [31:0]        w_rem_u;

  assign w_as64   = {{32{i_a[31]}}, i_a};
  assign w_bs64   = {{32{i_b[31]}}, i_b};
  assign w_prod_s = w_as64 * w_bs64;
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Divisor forced to 1 when zero so the divider never sees /0; the result is
  // discarded in that case. The most-negative / -1 case is pinned explicitly.
  assign w_bzero    = (i_b == 32'd0);
  assign w_bsafe    = w_bzero ? 32'sd1 : w_bs;
  assign w_div_edge = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
  assign w_quo_s    = w_div_edge ? w_as : (w_as / w_bsafe);
  assign w_rem_s    = w_div_edge ? 32'sd0 : (w_as % w_bsafe);
  assign w_quo_u    = i_a / $unsigned(w_bsafe);
  assign w_rem_u    = i_a % $unsigned(w_bsafe);
`endif

  always_comb begin
    o_c  = '0;
    o_ov = 1'b0;
    o_dz = 1'b0;
    case (i_f)
      ALU_ADD: begin
        o_c  = {32'd0, w_sum};
        o_ov = w_add_ov;
      end
      ALU_ADDU: o_c = {32'd0, w_sum};
      ALU_SUB: begin
        o_c  = {32'd0, w_dif};
        o_ov = w_sub_ov;
      end
      ALU_SUBU: o_c = {32'd0, w_dif};
      ALU_AND:  o_c = {32'd0, i_a & i_b};
      ALU_OR:   o_c = {32'd0, i_a | i_b};
      ALU_XOR:  o_c = {32'd0, i_a ^ i_b};
      ALU_SLT:  o_c = {63'd0, (w_as < w_bs)};
      ALU_SLTU: o_c = {63'd0, (i_a < i_b)};
      ALU_SLL:  o_c = {32'd0, i_b << w_sh};
      ALU_SRL:  o_c = {32'd0, i_b >> w_sh};
      ALU_SRA:  o_c = {32'd0, w_bs >>> w_sh};
`ifdef ALU_MULDIV_EN
      ALU_MULT:  o_c = w_prod_s;
      ALU_MULTU: o_c = w_prod_u;
      ALU_DIV: begin
        o_c  = w_bzero ? 64'd0 : {w_rem_s, w_quo_s};
        o_dz = w_bzero;
      end
      ALU_DIVU: begin
        o_c  = w_bzero ? 64'd0 : {w_rem_u, w_quo_u};
        o_dz = w_bzero;
      end
`endif
      default: o_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// MIPS32 execute stage: opcode/funct decode to ALU function, branch resolution
// from result flags, and a registered copy of {dz,ov,si,ze} for exception logic.
module mips_exec_unit
  import mips_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  mips_exec_unit_if.slave bus
);

  alu_fn_e     w_fn;
  logic [63:0] w_c;
  logic        w_ze;
  logic        w_si;
  logic        w_ov;
  logic        w_dz;
  logic        w_branch;
  logic [3:0]  r_flags;

  always_comb begin
    w_fn = ALU_ADDU;
    if (bus.op == OP_RTYPE) begin
      case (bus.func)
        FN_ADD:            w_fn = ALU_ADD;
        FN_ADDU:           w_fn = ALU_ADDU;
        FN_SUB:            w_fn = ALU_SUB;
        FN_SUBU:           w_fn = ALU_SUBU;
        FN_AND:            w_fn = ALU_AND;
        FN_OR:             w_fn = ALU_OR;
        FN_XOR:            w_fn = ALU_XOR;
        FN_SLT:            w_fn = ALU_SLT;
        FN_SLTU:           w_fn = ALU_SLTU;
        FN_SLL,  FN_SLLV:  w_fn = ALU_SLL;
        FN_SRL,  FN_SRLV:  w_fn = ALU_SRL;
        FN_SRA,  FN_SRAV:  w_fn = ALU_SRA;
        FN_MULT:           w_fn = ALU_MULT;
        FN_MULTU:          w_fn = ALU_MULTU;
        FN_DIV:            w_fn = ALU_DIV;
        FN_DIVU:           w_fn = ALU_DIVU;
        default:           w_fn = ALU_ADDU;
      endcase
    end else begin
      // Loads/stores and unknown opcodes fall to ADDU for address generation.
      case (bus.op)
        OP_ADDI:  w_fn = ALU_ADD;
        OP_ADDIU: w_fn = ALU_ADDU;
        OP_SLTI:  w_fn = ALU_SLT;
        OP_SLTIU: w_fn = ALU_SLTU;
        OP_ANDI:  w_fn = ALU_AND;
        OP_ORI:   w_fn = ALU_OR;
        OP_XORI:  w_fn = ALU_XOR;
        OP_LUI:   w_fn = ALU_OR;
        OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_fn = ALU_SUBU;
        default:  w_fn = ALU_ADDU;
      endcase
    end
  end

  alu_core u_alu (
    .i_f  (w_fn),
    .i_a  (bus.a),
    .i_b  (bus.b),
    .o_c  (w_c),
    .o_ov (w_ov),
    .o_dz (w_dz)
  );

  assign w_ze = (w_c[31:0] == 32'd0);
  assign w_si = w_c[31];

  always_comb begin
    w_branch = 1'b0;
    case (bus.want)
      BR_NONE:   w_branch = 1'b0;
      BR_EQ:     w_branch = w_ze;
      BR_NE:     w_branch = ~w_ze;
      BR_LTZ:    w_branch = w_si;
      BR_GEZ:    w_branch = ~w_si;
      BR_LEZ:    w_branch = w_si | w_ze;
      BR_GTZ:    w_branch = ~w_si & ~w_ze;
      BR_ALWAYS: w_branch = 1'b1;
      default:   w_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_flags <= 4'd0;
    else if (bus.flag_en)
      r_flags <= {w_dz, w_ov, w_si, w_ze};
  end

  assign bus.alu_f   = w_fn;
  assign bus.c       = w_c;
  assign bus.ze      = w_ze;
  assign bus.si      = w_si;
  assign bus.ov      = w_ov;
  assign bus.dz      = w_dz;
  assign bus.branch  = w_branch;
  assign bus.flags_q = r_flags;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed bench for mips_exec_unit: combinational results through a
// scoreboard queue, then flag-register capture, hold and reset behaviour.
module tb_mips_exec_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mips_exec_unit_if u_if ();

  mips_exec_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  f;
    logic [63:0] c;
    logic [3:0]  flg;
    logic        br;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic [5:0] op_i, input logic [5:0] fn_i,
                       input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic [2:0] want_i);
    u_if.op   = op_i;
    u_if.func = fn_i;
    u_if.a    = a_i;
    u_if.b    = b_i;
    u_if.want = want_i;
  endtask

  // eflg is {dz,ov,si,ze}
  task automatic step(input string tag, input logic [5:0] op_i, input logic [5:0] fn_i,
                      input logic [31:0] a_i, input logic [31:0] b_i, input logic [2:0] want_i,
                      input logic [3:0] ef, input logic [63:0] ec, input logic [3:0] eflg,
                      input logic ebr);
    exp_t e;
    e.tag = tag; e.f = ef; e.c = ec; e.flg = eflg; e.br = ebr;
    sb.push_back(e);
    drive(op_i, fn_i, a_i, b_i, want_i);
    #2;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_alu_f"}, {60'd0, u_if.alu_f}, {60'd0, e.f});
      chk({e.tag, "_c"}, u_if.c, e.c);
      chk({e.tag, "_flags"}, {60'd0, u_if.dz, u_if.ov, u_if.si, u_if.ze}, {60'd0, e.flg});
      chk({e.tag, "_branch"}, {63'd0, u_if.branch}, {63'd0, e.br});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    u_if.flag_en = 1'b0;
    drive(6'h00, 6'h21, 32'd0, 32'd0, 3'b000);
    @(posedge clk); #1;
    chk("reset_flags_q", {60'd0, u_if.flags_q}, 64'd0);
    rst_n = 1'b1;

    // Arithmetic and overflow
    step("add_ov",  6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 3'b000, 4'h0, 64'h8000_0000, 4'b0110, 1'b0);
    step("addu",    6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1, 3'b000, 4'h1, 64'h8000_0000, 4'b0010, 1'b0);
    step("sub",     6'h00, 6'h22, 32'h5, 32'h7, 3'b000, 4'h2, 64'hFFFF_FFFE, 4'b0010, 1'b0);
    step("sub_ov",  6'h00, 6'h22, 32'h8000_0000, 32'h1, 3'b000, 4'h2, 64'h7FFF_FFFF, 4'b0100, 1'b0);
    step("subu_z",  6'h00, 6'h23, 32'h3, 32'h3, 3'b000, 4'h3, 64'h0, 4'b0001, 1'b0);
    step("and",     6'h00, 6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 4'h4, 64'hF000_F000, 4'b0010, 1'b0);
    step("or",      6'h00, 6'h25, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 4'h5, 64'hFFF0_FFF0, 4'b0010, 1'b0);
    step("xor",     6'h00, 6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 4'h6, 64'h0FF0_0FF0, 4'b0000, 1'b0);
    step("slt",     6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, 3'b000, 4'h7, 64'h1, 4'b0000, 1'b0);
    step("sltu",    6'h00, 6'h2B, 32'hFFFF_FFFF, 32'h1, 3'b000, 4'h8, 64'h0, 4'b0001, 1'b0);

    // Shifts and LUI
    step("sll",     6'h00, 6'h00, 32'h4, 32'h1, 3'b000, 4'h9, 64'h10, 4'b0000, 1'b0);
    step("sllv",    6'h00, 6'h04, 32'h24, 32'h1, 3'b000, 4'h9, 64'h10, 4'b0000, 1'b0);
    step("srl",     6'h00, 6'h02, 32'h4, 32'h8000_0000, 3'b000, 4'hA, 64'h0800_0000, 4'b0000, 1'b0);
    step("srlv",    6'h00, 6'h06, 32'h1F, 32'h8000_0000, 3'b000, 4'hA, 64'h1, 4'b0000, 1'b0);
    step("sra",     6'h00, 6'h03, 32'h4, 32'h8000_0000, 3'b000, 4'hB, 64'hF800_0000, 4'b0010, 1'b0);
    step("srav",    6'h00, 6'h07, 32'h4, 32'h4000_0000, 3'b000, 4'hB, 64'h0400_0000, 4'b0000, 1'b0);
    step("lui",     6'h0F, 6'h00, 32'h0, 32'h1234_0000, 3'b000, 4'h5, 64'h1234_0000, 4'b0000, 1'b0);

    // Immediate ops, memory, default decode
    step("addi_ov", 6'h08, 6'h00, 32'h7FFF_FFFF, 32'h1, 3'b000, 4'h0, 64'h8000_0000, 4'b0110, 1'b0);
    step("addiu",   6'h09, 6'h00, 32'h7FFF_FFFF, 32'h1, 3'b000, 4'h1, 64'h8000_0000, 4'b0010, 1'b0);
    step("slti",    6'h0A, 6'h00, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'b000, 4'h7, 64'h1, 4'b0000, 1'b0);
    step("sltiu",   6'h0B, 6'h00, 32'h1, 32'hFFFF_FFFF, 3'b000, 4'h8, 64'h1, 4'b0000, 1'b0);
    step("andi",    6'h0C, 6'h00, 32'hFFFF, 32'h00FF, 3'b000, 4'h4, 64'hFF, 4'b0000, 1'b0);
    step("ori",     6'h0D, 6'h00, 32'hF000, 32'h000F, 3'b000, 4'h5, 64'hF00F, 4'b0000, 1'b0);
    step("xori",    6'h0E, 6'h00, 32'hFF, 32'h0F, 3'b000, 4'h6, 64'hF0, 4'b0000, 1'b0);
    step("lw",      6'h23, 6'h00, 32'h1000, 32'h4, 3'b000, 4'h1, 64'h1004, 4'b0000, 1'b0);
    step("sw_wrap", 6'h2B, 6'h00, 32'hFFFF_FFFC, 32'h8, 3'b000, 4'h1, 64'h4, 4'b0000, 1'b0);
    step("fn_dflt", 6'h00, 6'h3F, 32'h2, 32'h3, 3'b000, 4'h1, 64'h5, 4'b0000, 1'b0);
    step("op_dflt", 6'h3F, 6'h22, 32'h2, 32'h3, 3'b000, 4'h1, 64'h5, 4'b0000, 1'b0);

    // Branches
    step("beq_t",   6'h04, 6'h00, 32'h5, 32'h5, 3'b001, 4'h3, 64'h0, 4'b0001, 1'b1);
    step("bne_nt",  6'h05, 6'h00, 32'h5, 32'h5, 3'b010, 4'h3, 64'h0, 4'b0001, 1'b0);
    step("bne_t",   6'h05, 6'h00, 32'h5, 32'h4, 3'b010, 4'h3, 64'h1, 4'b0000, 1'b1);
    step("blez_t",  6'h06, 6'h00, 32'h0, 32'h0, 3'b101, 4'h3, 64'h0, 4'b0001, 1'b1);
    step("blez_nt", 6'h06, 6'h00, 32'h5, 32'h0, 3'b101, 4'h3, 64'h5, 4'b0000, 1'b0);
    step("bgtz_nt", 6'h07, 6'h00, 32'h8000_0000, 32'h0, 3'b110, 4'h3, 64'h8000_0000, 4'b0010, 1'b0);
    step("bgtz_t",  6'h07, 6'h00, 32'h5, 32'h0, 3'b110, 4'h3, 64'h5, 4'b0000, 1'b1);
    step("bltz_t",  6'h01, 6'h00, 32'h8000_0000, 32'h0, 3'b011, 4'h3, 64'h8000_0000, 4'b0010, 1'b1);
    step("bgez_nt", 6'h01, 6'h00, 32'h8000_0000, 32'h0, 3'b100, 4'h3, 64'h8000_0000, 4'b0010, 1'b0);
    step("bgez_t",  6'h01, 6'h00, 32'h5, 32'h0, 3'b100, 4'h3, 64'h5, 4'b0000, 1'b1);
    step("br_all",  6'h04, 6'h00, 32'h1, 32'h2, 3'b111, 4'h3, 64'hFFFF_FFFF, 4'b0010, 1'b1);
    step("br_none", 6'h04, 6'h00, 32'h5, 32'h5, 3'b000, 4'h3, 64'h0, 4'b0001, 1'b0);

`ifdef ALU_MULDIV_EN
    step("mult",    6'h00, 6'h18, 32'hFFFF_FFFF, 32'h2, 3'b000, 4'hC, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 1'b0);
    step("multu",   6'h00, 6'h19, 32'hFFFF_FFFF, 32'h2, 3'b000, 4'hD, 64'h0000_0001_FFFF_FFFE, 4'b0010, 1'b0);
    step("div_neg", 6'h00, 6'h1A, 32'hFFFF_FFF9, 32'h2, 3'b000, 4'hE, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0010, 1'b0);
    step("div_min", 6'h00, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 4'hE, 64'h0000_0000_8000_0000, 4'b0010, 1'b0);
    step("div_z",   6'h00, 6'h1A, 32'h5, 32'h0, 3'b000, 4'hE, 64'h0, 4'b1001, 1'b0);
    step("divu",    6'h00, 6'h1B, 32'hFFFF_FFF9, 32'h2, 3'b000, 4'hF, 64'h0000_0001_7FFF_FFFC, 4'b0000, 1'b0);
    step("divu_z",  6'h00, 6'h1B, 32'h7, 32'h0, 3'b000, 4'hF, 64'h0, 4'b1001, 1'b0);
`else
    step("mult_off",  6'h00, 6'h18, 32'hFFFF_FFFF, 32'h2, 3'b000, 4'hC, 64'h0, 4'b0001, 1'b0);
    step("multu_off", 6'h00, 6'h19, 32'hFFFF_FFFF, 32'h2, 3'b000, 4'hD, 64'h0, 4'b0001, 1'b0);
    step("div_off",   6'h00, 6'h1A, 32'h5, 32'h0, 3'b000, 4'hE, 64'h0, 4'b0001, 1'b0);
    step("divu_off",  6'h00, 6'h1B, 32'h9, 32'h2, 3'b000, 4'hF, 64'h0, 4'b0001, 1'b0);
`endif

    // Flag register: capture, hold, recapture, reset priority
    @(negedge clk);
    u_if.flag_en = 1'b1;
    drive(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 3'b000);
    @(posedge clk); #1;
    chk("flags_cap_ov", {60'd0, u_if.flags_q}, {60'd0, 4'b0110});

    @(negedge clk);
    u_if.flag_en = 1'b0;
    drive(6'h00, 6'h23, 32'h3, 32'h3, 3'b000);
    @(posedge clk); #1;
    chk("flags_hold", {60'd0, u_if.flags_q}, {60'd0, 4'b0110});

    @(negedge clk);
    u_if.flag_en = 1'b1;
    @(posedge clk); #1;
    chk("flags_cap_ze", {60'd0, u_if.flags_q}, {60'd0, 4'b0001});

    @(negedge clk);
    rst_n = 1'b0;
    u_if.flag_en = 1'b1;
    drive(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 3'b000);
    #1;
    chk("comb_in_reset", u_if.c, 64'h8000_0000);
    @(posedge clk); #1;
    chk("flags_rst_prio", {60'd0, u_if.flags_q}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    u_if.flag_en = 1'b0;
    @(posedge clk); #1;
    chk("flags_post_rst", {60'd0, u_if.flags_q}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
# mips_exec_unit

Execute-stage arithmetic block of the single-cycle MIPS32 core: decodes opcode/funct into a 4-bit ALU function, computes a 64-bit result with zero/sign/overflow/divide-by-zero flags, and resolves the branch decision from the flags. Result, flags and branch decision are purely combinational, so they can drive HI/LO, the register file, RAM addressing, PC selection and CP0 exception logic in the same cycle. A small flag register holds the last flags for exception bookkeeping.

## Interface
- No parameters.
- clk  in  1  core clock; the flag register samples on the rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- op  in  6  inst[31:26].
- func  in  6  inst[5:0].
- a  in  32  operand A: rs, or the zero-extended shamt for immediate shifts.
- b  in  32  operand B: rt, the extended immediate, {imm,16'b0}, or 0.
- want  in  3  branch type from the main decoder.
- flag_en  in  1  capture flags into flags_q this cycle.
- alu_f  out  4  decoded function code.
- c  out  64  result; 32-bit ops drive c[63:32]=0.
- ze  out  1  c[31:0]==0.
- si  out  1  c[31].
- ov  out  1  signed overflow; ADD/SUB only.
- dz  out  1  DIV/DIVU with b==0.
- branch  out  1  branch taken.
- flags_q  out  4  registered {dz,ov,si,ze}.

## Operation
- Function codes: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 SLT (signed), 8 SLTU, 9 SLL, A SRL, B SRA, C MULT, D MULTU, E DIV, F DIVU. NOR is not supported.
- Shifts: shift b by a[4:0].
- SLT/SLTU: result is 1 or 0.
- MULT/MULTU: full 64-bit product.
- DIV/DIVU: c[63:32]=remainder, c[31:0]=quotient. Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives quotient 0x80000000, remainder 0, ov=0.
  - b==0 gives c=0 and dz=1.
- ov is 0 for every op other than ADD and SUB.
- Decode, op==0 (by funct):
  - 20→ADD, 21→ADDU, 22→SUB, 23→SUBU, 24→AND, 25→OR, 26→XOR, 2A→SLT, 2B→SLTU.
  - 00/04→SLL, 02/06→SRL, 03/07→SRA.
  - 18→MULT, 19→MULTU, 1A→DIV, 1B→DIVU.
  - any other funct→ADDU.
- Decode, other opcodes:
  - 08→ADD, 09→ADDU, 0A→SLT, 0B→SLTU, 0C→AND, 0D→OR, 0E→XOR, 0F (LUI)→OR.
  - 01/04/05/06/07 (branches)→SUBU.
  - 20–2B (loads/stores)→ADDU.
  - any other opcode→ADDU.
- Branch, want→branch:
  - 000→0.
  - 001 EQ→ze.
  - 010 NE→!ze.
  - 011 LTZ→si.
  - 100 GEZ→!si.
  - 101 LEZ→si|ze.
  - 110 GTZ→!si&!ze.
  - 111→1.
- The flag register updates only when flag_en=1; it holds otherwise.

## Timing
- All outputs except flags_q are combinational, with zero-cycle latency from op/func/a/b/want.
- flags_q: one-cycle latency.
- rst_n=0 at a rising edge sets flags_q=0. Reset takes priority over a simultaneous flag_en.
- Reset does not affect the combinational outputs.
- Divide/multiply complete within the cycle; there is no handshake or busy signal.

## Configuration
- ALU_MULDIV_EN defined: codes C–F are implemented as specified.
- ALU_MULDIV_EN undefined: codes C–F produce c=0, dz=0, ov=0. Decode is unchanged.

## Structure
- Package mips_alu_pkg holds:
  - function-code constants;
  - opcode/funct constants;
  - branch-type constants.
- Sub-module alu_core holds the combinational arithmetic (f, a, b → c, flags).
- Decode, branch logic and the flag register live in mips_exec_unit.

## Test plan
- Overflow: op=0, func=20, a=7FFFFFFF, b=1 → alu_f=0, c[31:0]=80000000, ov=1, si=1. The same operands with func=21 → ov=0.
- Signed divide: op=0, func=1A, a=FFFFFFF9 (-7), b=2 → c=FFFFFFFF_FFFFFFFD.
- Divide by zero: op=0, func=1A, b=0 → c=0, dz=1.
- Signed multiply: func=18, a=FFFFFFFF, b=2 → c=FFFFFFFF_FFFFFFFE.
- Unsigned multiply: func=19, a=FFFFFFFF, b=2 → c=00000001_FFFFFFFE.
- Shift and LUI:
  - func=03, a=4, b=80000000 → c[31:0]=F8000000.
  - op=0F, a=0, b=12340000 → c[31:0]=12340000.
- Branches:
  - op=04, a=b=5, want=001 → branch=1.
  - want=010, same operands → branch=0.
  - op=06, a=0, b=0, want=101 → branch=1.
  - op=07, a=80000000, b=0, want=110 → branch=0.
- Flag register:
  - flag_en=1 on ADD overflow → flags_q=0110 on the next cycle.
  - rst_n=0 with flag_en=1 → flags_q=0.
  - Under the no-muldiv build, func=18 → c=0.
